// File: rtl/mul_div_arbiter.sv
// -----------------------------------------------------------------------------
// mul_div_arbiter
// Two-requester round-robin front end for the shared floating-point mul_div
// unit. Accepts one operation at a time over valid/ready, issues it to the
// unit with a single-cycle md_en pulse, waits LATENCY cycles, captures the
// result and IEEE flags and returns them on a shared response channel tagged
// with the requester ID. Operands and results pass through bit-exact.
//
// Ports:
//   clk, arst                  clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_a/_b/_sel         operands and op select (0 = mul, 1 = div)
//   md_en/md_a/md_b/md_sel     issue pulse and operands to the unit
//   md_r/md_flags              unit result and flags {i,uf,of,dz,io}
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_r/rsp_flags     owning requester, captured result and flags
//   busy                       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mul_div_arbiter #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2     // legal range 1..15
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sel,
   output logic             md_en,
   output logic [WIDTH-1:0] md_a,
   output logic [WIDTH-1:0] md_b,
   output logic             md_sel,
   input  logic [WIDTH-1:0] md_r,
   input  logic [4:0]       md_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_r,
   output logic [4:0]       rsp_flags,
   output logic             busy
);

   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sel_q, sel_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [4:0]       flags_q, flags_d;

   logic             grant;
   logic             any_valid;

   // Round-robin pick: a lone requester always wins; on a tie the requester
   // that was not granted last time wins.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_q;
      end else begin
         grant = req1_valid;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      sel_d      = sel_q;
      id_d       = id_q;
      r_d        = r_q;
      flags_d    = flags_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      md_en      = 1'b0;
      rsp_valid  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Ready is gated by arst so it reads 0 while reset is held.
            req0_ready = arst & req0_valid & ~grant;
            req1_ready = arst & req1_valid &  grant;
            if (any_valid) begin
               a_d     = grant ? req1_a   : req0_a;
               b_d     = grant ? req1_b   : req0_b;
               sel_d   = grant ? req1_sel : req0_sel;
               id_d    = grant;
               last_d  = grant;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            md_en   = 1'b1;
            cnt_d   = LAT;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Counter value 1 marks the edge at which the unit output is valid.
            if (cnt_q <= 4'd1) begin
               r_d     = md_r;
               flags_d = md_flags;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         id_q    <= 1'b0;
         r_q     <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         id_q    <= id_d;
         r_q     <= r_d;
         flags_q <= flags_d;
      end
   end

   assign md_a      = a_q;
   assign md_b      = b_q;
   assign md_sel    = sel_q;
   assign rsp_id    = id_q;
   assign rsp_r     = r_q;
   assign rsp_flags = flags_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_div_arbiter
// Directed bench for mul_div_arbiter with LATENCY=2. A small model of the
// mul_div unit presents its result only during the single cycle in which the
// arbiter must capture it; elsewhere it drives junk.
// -----------------------------------------------------------------------------
module tb_mul_div_arbiter;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_sel = 1'b0, req1_sel = 1'b0;
   logic        md_en;
   logic [31:0] md_a, md_b;
   logic        md_sel;
   logic [31:0] md_r;
   logic [4:0]  md_flags;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_id;
   logic [31:0] rsp_r;
   logic [4:0]  rsp_flags;
   logic        busy;

   int tests = 0;
   int fails = 0;

   mul_div_arbiter #(.WIDTH(32), .LATENCY(2)) dut (
      .clk        (clk),
      .arst       (arst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sel   (req0_sel),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sel   (req1_sel),
      .md_en      (md_en),
      .md_a       (md_a),
      .md_b       (md_b),
      .md_sel     (md_sel),
      .md_r       (md_r),
      .md_flags   (md_flags),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_r      (rsp_r),
      .rsp_flags  (rsp_flags),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Unit model: result valid only in the second cycle after the md_en cycle.
   logic        d1 = 1'b0, d2 = 1'b0;
   logic [31:0] ma = '0, mb = '0;
   logic        ms = 1'b0;

   always @(posedge clk) begin
      d1 <= md_en;
      d2 <= d1;
      if (md_en) begin
         ma <= md_a;
         mb <= md_b;
         ms <= md_sel;
      end
   end

   always_comb begin
      md_r     = 32'hDEADBEEF;
      md_flags = 5'h1F;
      if (d2) begin
         if (ma == 32'h3FC00000 && mb == 32'h40000000 && !ms) begin
            md_r     = 32'h40400000;
            md_flags = 5'b00000;
         end else if (ma == 32'h3F800000 && mb == 32'h00000000 && ms) begin
            md_r     = 32'h7F800000;
            md_flags = 5'b00010;
         end else begin
            md_r     = ma ^ mb;
            md_flags = ma[4:0] ^ mb[4:0];
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // One isolated operation with exact cycle-by-cycle timing checks.
   task automatic single_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                            input logic sel, input logic [31:0] er, input logic [4:0] ef,
                            input string nm);
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
      end
      rsp_ready = 1'b1;   // held high early: must be ignored until RESP
      settle();
      chk({nm, "_ready"}, {req0_ready, req1_ready}, id ? 2'b01 : 2'b10);
      step();             // A+1
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      settle();
      chk({nm, "_issue"}, {md_en, busy, md_sel, req0_ready, req1_ready}, {1'b1, 1'b1, sel, 2'b00});
      chk({nm, "_md_ab"}, {md_a, md_b}, {a, b});
      step();             // A+2
      chk({nm, "_a2"}, {md_en, rsp_valid}, 2'b00);
      step();             // A+3
      chk({nm, "_a3"}, {md_en, rsp_valid, md_a}, {2'b00, a});
      step();             // A+4
      chk({nm, "_rsp"}, {rsp_valid, rsp_id, rsp_flags, rsp_r}, {1'b1, id, ef, er});
      step();             // A+5, response consumed at end of A+4
      rsp_ready = 1'b0;
      chk({nm, "_done"}, {rsp_valid, busy}, 2'b00);
   endtask

   initial begin
      int  n;
      logic eid;

      // Reset, with both requesters pushing to check ready stays low.
      #1 arst = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      settle();
      chk("rst_ctl", {req0_ready, req1_ready, md_en, md_sel, rsp_valid, rsp_id, busy}, 7'b0);
      chk("rst_data", {md_a, md_b}, 64'h0);
      chk("rst_rsp", {27'h0, rsp_flags, rsp_r}, 64'h0);
      step();
      step();
      chk("rst_hold", {req0_ready, req1_ready, md_en, rsp_valid, busy}, 5'b0);
      arst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();

      single_op(1'b0, 32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000, "mul");
      single_op(1'b1, 32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 5'b00010, "dz");

      // Round-robin: last grant was req1, so ties go 0,1,0,1.
      req0_a = 32'h1;  req0_b = 32'h2;  req0_sel = 1'b0;
      req1_a = 32'h10; req1_b = 32'h20; req1_sel = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         eid = i[0];
         settle();
         chk("rr_grant", {req0_ready, req1_ready}, eid ? 2'b01 : 2'b10);
         step();
         n = 0;
         while (rsp_valid !== 1'b1 && n < 20) begin
            chk("rr_noready", {req0_ready, req1_ready}, 2'b00);
            step();
            n++;
         end
         chk("rr_latency", n, 3);
         chk("rr_rsp", {rsp_valid, rsp_id, rsp_flags, rsp_r},
             eid ? {1'b1, 1'b1, 5'h10, 32'h30} : {1'b1, 1'b0, 5'h03, 32'h3});
         rsp_ready = 1'b1;
         if (i == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         step();
         rsp_ready = 1'b0;
      end
      chk("rr_idle", {busy, rsp_valid}, 2'b00);

      // Backpressure on a req1 op while req0 waits.
      req1_valid = 1'b1; req1_a = 32'h12345678; req1_b = 32'h0F0F0F0F; req1_sel = 1'b1;
      settle();
      chk("bp_grant", {req0_ready, req1_ready}, 2'b01);
      step();             // A+1
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h3; req0_sel = 1'b0;
      settle();
      chk("bp_issue", {req0_ready, req1_ready, md_en, md_sel}, 4'b0011);
      step();
      step();
      step();             // A+4
      for (int k = 0; k < 10; k++) begin
         chk("bp_hold_rsp", {rsp_valid, rsp_id, rsp_flags, rsp_r}, {1'b1, 1'b1, 5'h17, 32'h1D3B5977});
         chk("bp_hold_ctl", {req0_ready, req1_ready, md_en, busy}, 4'b0001);
         step();
      end
      rsp_ready = 1'b1;
      settle();
      chk("bp_last", {rsp_valid, rsp_r}, {1'b1, 32'h1D3B5977});
      step();             // R+1
      rsp_ready = 1'b0;
      settle();
      chk("bp_release", {busy, rsp_valid, req0_ready, req1_ready}, 4'b0010);
      step();             // ISSUE of req0 op, last becomes 0
      req0_valid = 1'b0;
      chk("rst_op_issue", {md_en, md_a}, {1'b1, 32'h5});
      step();             // WAIT

      // Reset during WAIT, with both requesters pushing.
      arst = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      settle();
      chk("midrst_ctl", {req0_ready, req1_ready, md_en, md_sel, rsp_valid, rsp_id, busy}, 7'b0);
      chk("midrst_data", {md_a, md_b}, 64'h0);
      chk("midrst_rsp", {27'h0, rsp_flags, rsp_r}, 64'h0);
      step();
      arst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("midrst_quiet", {rsp_valid, md_en, busy}, 3'b000);
         step();
      end

      // Tie after reset must go to req0 again.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      settle();
      chk("midrst_tie", {req0_ready, req1_ready}, 2'b10);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("post_rst_latency", n, 3);
      chk("post_rst_rsp", {rsp_valid, rsp_id, rsp_flags, rsp_r}, {1'b1, 1'b0, 5'h06, 32'h6});
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("post_rst_done", {rsp_valid, busy}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mul_div_arbiter.md
# mul_div_arbiter

Two-requester round-robin controller for the shared floating-point `mul_div` unit. It accepts operations over valid/ready handshakes and issues one operation at a time to the unit with a single-cycle `en` pulse. It waits a fixed unit latency, captures the result and IEEE flags, and returns them on a shared response channel tagged with the requester ID. It sits between the two client datapaths and the single `mul_div` instance.

## Interface
- `WIDTH`, 32, operand/result width (IEEE-754 single).
- `LATENCY`, 2, cycles from the `md_en` cycle to a valid `md_r`/flags. Legal range 1..15.

- `clk`  in  1  clock, rising edge.
- `arst`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request valid, per requester.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_sel`, `req1_sel`  in  1  0 = multiply, 1 = divide.
- `md_en`  out  1  one-cycle issue pulse to the unit.
- `md_a`, `md_b`  out  WIDTH  operands to the unit.
- `md_sel`  out  1  operation select to the unit.
- `md_r`  in  WIDTH  unit result.
- `md_flags`  in  5  unit flags: [0] io, [1] dz, [2] of, [3] uf, [4] i.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_r`  out  WIDTH  captured result.
- `rsp_flags`  out  5  captured flags, same bit order as `md_flags`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester and assert that requester's `reqN_ready` combinationally.
  - On the handshake, latch a, b, sel and id into `md_a`/`md_b`/`md_sel`/`rsp_id`, then go to ISSUE.
  - At most one `ready` is high in any cycle.
- **Arbitration:** round-robin with a `last` register.
  - Exactly one valid: that requester wins, regardless of `last`.
  - Both valid: the requester ≠ `last` wins.
  - `last` updates only on a handshake. Reset value is 1, so requester 0 wins the first tie.
- **ISSUE:** `md_en`=1 for exactly this cycle. Load the counter with `LATENCY`, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `md_r` and `md_flags` into `rsp_r`/`rsp_flags` on that edge, then go to RESP.
  - `md_a`/`md_b`/`md_sel` stay stable from ISSUE until the capture edge.
- **RESP**
  - `rsp_valid`=1, with `rsp_id`/`rsp_r`/`rsp_flags` held stable until `rsp_ready`.
  - When `rsp_valid && rsp_ready`, go to IDLE. `rsp_valid` drops the next cycle.
- Both `reqN_ready` are 0 in every state except IDLE. Requests held across a busy period are arbitrated on return to IDLE.
- Operands pass through bit-exact. The block does no arithmetic and does not interpret the flags.

## Timing
- Reset (`arst`=0, asynchronous): state=IDLE, `last`=1, counter=0.
  - All outputs 0: `req*_ready`, `md_en`, `md_a`, `md_b`, `md_sel`, `rsp_valid`, `rsp_id`, `rsp_r`, `rsp_flags`, `busy`.
- Request handshake in cycle A:
  - `md_en` is high in A+1.
  - Result is captured at the end of cycle A+1+LATENCY.
  - `rsp_valid` is high from A+2+LATENCY. With LATENCY=2, `rsp_valid` rises in A+4.
- Response handshake in cycle R: the earliest next request handshake is R+1. Maximum throughput is one op per LATENCY+3 cycles.
- Reset asserted mid-operation (ISSUE, WAIT or RESP): the in-flight op is discarded, no response is produced, and `md_en` stays 0.
  - After release, operation resumes from IDLE with `last`=1.
- `rsp_ready` high while `rsp_valid`=0 is ignored.
- A requester's valid may drop before it is granted. No grant is then issued to it.

## Test plan
- Mul, req0 only, LATENCY=2: a=0x3FC00000 (1.5), b=0x40000000 (2.0), sel=0 at cycle A.
  - Expect `md_en` only in A+1, and `rsp_valid` in A+4 with `rsp_id`=0, `rsp_r`=0x40400000, `rsp_flags`=0.
- Divide by zero, req1: a=0x3F800000 (1.0), b=0x00000000, sel=1.
  - Expect `rsp_id`=1, `rsp_r`=0x7F800000, `rsp_flags`[1]=1.
- Round-robin: both valid continuously for 4 ops.
  - Expect grant order 0,1,0,1, exactly one `ready` per IDLE cycle, and `rsp_id` matching the order.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP.
  - Expect `rsp_*` stable, both `req*_ready`=0, `md_en`=0, `busy`=1. Release: IDLE one cycle after the handshake.
- Reset mid-WAIT: pull `arst` low for 1 cycle during WAIT.
  - Expect all outputs 0 immediately and no `rsp_valid` for that op. The next tie is granted to req0.
